// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg
//   Shared types and width helpers for the step controller.
//   mode_t     : operating mode of the step controller FSM.
//   cnt_width(): bits needed by a counter that runs 0..n-1 (never below 1).
package step_ctrl_pkg;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Board defaults: 20 ms debounce and a 1 Hz run rate at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int RUN_DIV_DEF         = 50000000;
    localparam int DB_CNT_W_DEF        = cnt_width(DEBOUNCE_CYCLES_DEF);
    localparam int RUN_CNT_W_DEF       = cnt_width(RUN_DIV_DEF);

endpackage

// File: rtl/step_ctrl_debounce_sync.sv
// debounce_sync
//   Two-flop synchronizer followed by a counting debouncer for one raw,
//   asynchronous, bouncy input.
//   Ports:
//     clk    in  board clock
//     reset  in  synchronous, active-high reset
//     din    in  raw asynchronous level (already in the wanted polarity)
//     dout   out debounced level; changes only after DEBOUNCE_CYCLES
//                consecutive synced samples that differ from it
module debounce_sync
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            // Any sample agreeing with the stable value restarts the count,
            // so only an uninterrupted run of differing samples flips it.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl
//   Turns a raw DE2 pushbutton and slide switch into a one-cycle processor
//   clock-enable. Step mode: one pulse per debounced key press. Run mode:
//   one pulse every RUN_DIV cycles. Counts issued pulses for display.
//   Ports:
//     clk         in  board clock (50 MHz)
//     reset       in  synchronous, active-high reset
//     key_n       in  raw KEY, active-low, asynchronous, bouncy
//     run_sw      in  raw SW, 1 = run mode, asynchronous, bouncy
//     step_en     out one-cycle clock-enable pulse
//     key_pressed out debounced key level (1 = pressed)
//     running     out 1 while in run mode
//     step_count  out number of step_en pulses since reset (wraps)
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RUN_DIV         = RUN_DIV_DEF,
    parameter int COUNT_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_n,
    input  logic               run_sw,
    output logic               step_en,
    output logic               key_pressed,
    output logic               running,
    output logic [COUNT_W-1:0] step_count
);

    localparam int RCW = cnt_width(RUN_DIV);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(RUN_DIV - 1);

    logic               key_db;
    logic               sw_db;
    logic               key_prev_q;
    mode_t              mode_q;
    mode_t              mode_d;
    logic [RCW-1:0]     run_cnt_q;
    logic [RCW-1:0]     run_cnt_d;
    logic               step_en_q;
    logic               step_en_d;
    logic [COUNT_W-1:0] step_count_q;

    // Key is inverted before synchronizing so the debounced level reads
    // 1 = pressed.
    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk  (clk),
        .reset(reset),
        .din  (~key_n),
        .dout (key_db)
    );

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk  (clk),
        .reset(reset),
        .din  (run_sw),
        .dout (sw_db)
    );

    always_comb begin
        mode_d    = sw_db ? MODE_RUN : MODE_STEP;
        run_cnt_d = run_cnt_q;
        step_en_d = 1'b0;
        if (mode_d != mode_q) begin
            // Mode change: restart the run divider and drop any key edge
            // that happens to coincide with the switch.
            run_cnt_d = '0;
        end else if (mode_q == MODE_RUN) begin
            if (run_cnt_q == RUN_LAST) begin
                run_cnt_d = '0;
                step_en_d = 1'b1;
            end else begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end else begin
            step_en_d = key_db & ~key_prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q   <= 1'b0;
            mode_q       <= MODE_STEP;
            run_cnt_q    <= '0;
            step_en_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            key_prev_q <= key_db;
            mode_q     <= mode_d;
            run_cnt_q  <= run_cnt_d;
            step_en_q  <= step_en_d;
            if (step_en_d) begin
                step_count_q <= step_count_q + 1'b1;
            end
        end
    end

    assign step_en     = step_en_q;
    assign key_pressed = key_db;
    assign running     = (mode_q == MODE_RUN);
    assign step_count  = step_count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl
//   Drives directed and randomized key/switch waveforms into step_ctrl and
//   compares every output each cycle against a reference model built from
//   per-edge histories of the sampled inputs.
module tb_step_ctrl;

    localparam int D  = 4;
    localparam int R  = 5;
    localparam int CW = 4;
    localparam int HN = 8192;

    logic          clk;
    logic          reset;
    logic          key_n;
    logic          run_sw;
    logic          step_en;
    logic          key_pressed;
    logic          running;
    logic [CW-1:0] step_count;

    int tests;
    int errors;
    int cyc;

    // Reference model state: histories indexed by edge number since reset.
    bit kraw [HN];
    bit sraw [HN];
    bit kqh  [HN];
    bit sqh  [HN];
    bit modeh[HN];
    int n;
    int kstreak;
    int sstreak;
    int enter;
    int exp_step;
    int exp_cnt;

    step_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .RUN_DIV        (R),
        .COUNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .run_sw     (run_sw),
        .step_en    (step_en),
        .key_pressed(key_pressed),
        .running    (running),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs present at it.
    task automatic model_edge();
        bit ks, ss, kq, sq, st;
        if (reset) begin
            n = 0; kqh[0] = 0; sqh[0] = 0; modeh[0] = 0;
            kstreak = 0; sstreak = 0; enter = 0; exp_step = 0; exp_cnt = 0;
            return;
        end
        n++;
        kraw[n] = ~key_n;
        sraw[n] = run_sw;
        // Two synchronizer stages: the debouncer sees the level from two edges ago.
        ks = (n >= 3) ? kraw[n-2] : 1'b0;
        ss = (n >= 3) ? sraw[n-2] : 1'b0;
        kq = kqh[n-1];
        if (ks != kq) begin
            kstreak++;
            if (kstreak == D) begin kq = ks; kstreak = 0; end
        end else kstreak = 0;
        kqh[n] = kq;
        sq = sqh[n-1];
        if (ss != sq) begin
            sstreak++;
            if (sstreak == D) begin sq = ss; sstreak = 0; end
        end else sstreak = 0;
        sqh[n] = sq;
        modeh[n] = sqh[n-1];
        if (modeh[n] && !modeh[n-1]) enter = n;
        if (modeh[n] != modeh[n-1]) st = 0;
        else if (modeh[n]) st = ((n - enter) % R) == 0;
        else st = (n >= 2) && kqh[n-1] && !kqh[n-2];
        exp_step = int'(st);
        if (st) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk("step_en",     32'(step_en),     32'(exp_step));
        chk("key_pressed", 32'(key_pressed), 32'(kqh[n]));
        chk("running",     32'(running),     32'(modeh[n]));
        chk("step_count",  32'(step_count),  32'(exp_cnt));
    endtask

    task automatic hold(input logic k, input logic s, input int cycles);
        key_n  = k;
        run_sw = s;
        repeat (cycles) tick();
    endtask

    // Bouncy key (and optionally switch) with random segment lengths.
    task automatic random_phase(input int cycles, input bit allow_sw);
        int left;
        int len;
        left = cycles;
        while (left > 0) begin
            len   = $urandom_range(1, 9);
            key_n = 1'($urandom_range(0, 1));
            if (allow_sw && $urandom_range(0, 7) == 0) run_sw = ~run_sw;
            if (len > left) len = left;
            repeat (len) tick();
            left -= len;
        end
    endtask

    initial begin
        bit bpat[5];
        tests = 0; errors = 0; cyc = 0;
        n = 0; kstreak = 0; sstreak = 0; enter = 0; exp_step = 0; exp_cnt = 0;
        kqh[0] = 0; sqh[0] = 0; modeh[0] = 0;
        bpat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset with key pressed and switch on: outputs must stay cleared.
        reset = 1'b1; key_n = 1'b0; run_sw = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (12) tick();
        hold(1'b1, 1'b0, 25);

        // Clean press held then released.
        hold(1'b0, 1'b0, 20);
        hold(1'b1, 1'b0, 20);

        // Bounce pattern, then held, then released.
        for (int i = 0; i < 5; i++) hold(bpat[i], 1'b0, 1);
        hold(1'b0, 1'b0, 15);
        hold(1'b1, 1'b0, 15);

        // Bouncy key in step mode.
        random_phase(300, 1'b0);

        // Run mode long enough to wrap the 4-bit count; key presses ignored.
        key_n  = 1'b1;
        run_sw = 1'b1;
        random_phase(110, 1'b0);

        // One-cycle reset mid-run with the switch still on.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        random_phase(60, 1'b0);

        // Back to step mode, then mixed random key and switch activity.
        hold(1'b1, 1'b0, 30);
        random_phase(800, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
